// File: rtl/frame_writer_pkg.sv
// Shared constants, FSM encoding and FIFO entry layout for the framebuffer writer.
package frame_writer_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int ADDR_W   = 17;
  localparam int COLOR_W  = 3;
  localparam int COORD_W  = 10;
  localparam int FB_SIZE  = SCREEN_W * SCREEN_H;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pix_t;
endpackage

// File: rtl/frame_writer_if.sv
// Pixel-write input and framebuffer memory port bundled for the frame writer.
interface frame_writer_if;
  import frame_writer_pkg::*;

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COLOR_W-1:0] color;
  logic               writeEn;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_data;
  logic               mem_we;
  logic               mem_ready;

  modport master (
    input  x, y, color, writeEn, mem_ready,
    output mem_addr, mem_data, mem_we
  );

  modport slave (
    output x, y, color, writeEn, mem_ready,
    input  mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of {addr, color}; push and pop on the same edge are legal even when full.
module pixel_fifo
  import frame_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  pix_t din,
  output pix_t head,
  output logic full,
  output logic empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/frame_writer.sv
// Bounds-checks plots, queues them as linear addresses and drains them to memory; also sweeps a full-screen clear.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int                 SCREEN_W   = frame_writer_pkg::SCREEN_W,
  parameter int                 SCREEN_H   = frame_writer_pkg::SCREEN_H,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [COLOR_W-1:0] BG_COLOR   = 3'b000
) (
  input  logic           clk,
  input  logic           reset_n,
  frame_writer_if.master bus,
  input  logic           clear,
  output logic           busy,
  output logic           overflow
);
  localparam int FB = SCREEN_W * SCREEN_H;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] sweep, plot_addr;
  logic              in_bounds, push, pop, full, empty, sweep_last;
  pix_t              head, plot;

  assign in_bounds = bus.writeEn && (32'(bus.x) < SCREEN_W) && (32'(bus.y) < SCREEN_H);
  assign plot_addr = ADDR_W'(bus.y) * ADDR_W'(SCREEN_W) + ADDR_W'(bus.x);
  assign plot      = '{addr: plot_addr, color: bus.color};

  // Queued plots are held back during the sweep so they land on top of the background.
  assign pop        = (state != S_CLEAR) && !empty && bus.mem_ready;
  assign push       = in_bounds && (!full || pop);
  assign sweep_last = (sweep == ADDR_W'(FB - 1));

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset_n),
    .push  (push),
    .pop   (pop),
    .din   (plot),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state <= S_RUN;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)                                sweep <= '0;
    else if (state == S_FLUSH)                  sweep <= '0;
    else if (state == S_CLEAR && bus.mem_ready) sweep <= sweep + 1'b1;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)                overflow <= 1'b0;
    else if (in_bounds && !push) overflow <= 1'b1;
  end

  always_comb begin
    state_nxt    = state;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_data = '0;
    case (state)
      S_RUN: begin
        if (!empty) begin
          bus.mem_we   = 1'b1;
          bus.mem_addr = head.addr;
          bus.mem_data = head.color;
        end
        if (clear) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (!empty) begin
          bus.mem_we   = 1'b1;
          bus.mem_addr = head.addr;
          bus.mem_data = head.color;
        end else begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = sweep;
        bus.mem_data = BG_COLOR;
        if (bus.mem_ready && sweep_last) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  assign busy = (state != S_RUN);
endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer: expected writes queued at stimulus time, checked at the memory port.
module tb_frame_writer;
  localparam logic [2:0] BG = 3'b101;
  localparam int         FBN = 320 * 240;

  typedef struct packed {
    logic [16:0] addr;
    logic [2:0]  data;
  } wr_t;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] c;
    bit         valid;
    int         addr;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic clear;
  logic busy, overflow;

  frame_writer_if bus();

  frame_writer #(.FIFO_DEPTH(4), .BG_COLOR(BG)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .clear    (clear),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  nwr   = 0;

  // A write is committed at the next rising edge when mem_we && mem_ready are seen here.
  always @(negedge clk) begin
    if (!reset_n && bus.mem_we && bus.mem_ready) begin
      wr_t e;
      nwr++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, want none", bus.mem_addr, bus.mem_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_data !== e.data) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%0d, want addr=%0d data=%0d",
                   bus.mem_addr, bus.mem_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int px, input int py, input logic [2:0] c);
    bus.x       = 10'(px);
    bus.y       = 10'(py);
    bus.color   = c;
    bus.writeEn = 1'b1;
  endtask

  task automatic plot(input int px, input int py, input logic [2:0] c, input bit expect_it);
    drive(px, py, c);
    if (expect_it) exp_q.push_back('{addr: 17'(py * 320 + px), data: c});
  endtask

  task automatic drain(input string nm, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic push_sweep(input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back('{addr: 17'(i), data: BG});
  endtask

  vec_t vecs[9];
  int   base, n;

  initial begin
    vecs[0] = '{x: 5,    y: 2,    c: 3'b110, valid: 1'b1, addr: 645};
    vecs[1] = '{x: 320,  y: 0,    c: 3'b001, valid: 1'b0, addr: 0};
    vecs[2] = '{x: 0,    y: 240,  c: 3'b010, valid: 1'b0, addr: 0};
    vecs[3] = '{x: 319,  y: 239,  c: 3'b111, valid: 1'b1, addr: 76799};
    vecs[4] = '{x: 0,    y: 0,    c: 3'b011, valid: 1'b1, addr: 0};
    vecs[5] = '{x: 1023, y: 1023, c: 3'b100, valid: 1'b0, addr: 0};
    vecs[6] = '{x: 100,  y: 100,  c: 3'b011, valid: 1'b1, addr: 32100};
    vecs[7] = '{x: 319,  y: 0,    c: 3'b101, valid: 1'b1, addr: 319};
    vecs[8] = '{x: 0,    y: 239,  c: 3'b010, valid: 1'b1, addr: 76480};

    reset_n = 1'b1; clear = 1'b0;
    bus.x = '0; bus.y = '0; bus.color = '0; bus.writeEn = 1'b0; bus.mem_ready = 1'b0;
    tick();
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_data", bus.mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    #2 reset_n = 1'b0;
    tick();

    // Single plot: one-cycle latency, one-cycle write.
    bus.mem_ready = 1'b1;
    plot(5, 2, 3'b110, 1'b1);
    tick();
    bus.writeEn = 1'b0;
    chk("single_we", bus.mem_we, 1);
    chk("single_addr", bus.mem_addr, 645);
    chk("single_data", bus.mem_data, 3'b110);
    tick();
    chk("single_we_drop", bus.mem_we, 0);

    // Table: bounds and address arithmetic.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].x, vecs[i].y, vecs[i].c);
      if (vecs[i].valid) exp_q.push_back('{addr: 17'(vecs[i].addr), data: vecs[i].c});
      tick();
      bus.writeEn = 1'b0;
      chk($sformatf("vec%0d_we", i), bus.mem_we, 32'(vecs[i].valid));
      tick();
      chk($sformatf("vec%0d_ovf", i), overflow, 0);
    end
    drain("table_drain", 50);

    // Full FIFO with pop and push on every edge.
    base = nwr;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      plot(10 + i, 3, 3'(i), 1'b1);
      tick();
    end
    bus.mem_ready = 1'b1;
    for (int i = 4; i < 12; i++) begin
      plot(10 + i, 3, 3'(i), 1'b1);
      tick();
    end
    bus.writeEn = 1'b0;
    drain("full_drain", 50);
    chk("full_ovf", overflow, 0);
    chk("full_count", nwr - base, 12);

    // Backpressure: the fifth plot overflows, only the first four are written.
    base = nwr;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      plot(i, 0, 3'b001, i < 4);
      tick();
      if (i == 3) chk("bp_ovf_before", overflow, 0);
      if (i == 4) chk("bp_ovf_after", overflow, 1);
    end
    bus.writeEn = 1'b0;
    tick(); tick();
    chk("bp_stalled", nwr - base, 0);
    bus.mem_ready = 1'b1;
    drain("bp_drain", 50);
    tick(); tick(); tick();
    chk("bp_count", nwr - base, 4);

    // Clear with two queued pixels, a plot and an ignored clear mid-sweep.
    bus.mem_ready = 1'b0;
    plot(7, 1, 3'b010, 1'b1);
    tick();
    plot(8, 1, 3'b011, 1'b1);
    tick();
    bus.writeEn = 1'b0;
    push_sweep(FBN);
    base = nwr;
    clear = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy_rise", busy, 1);
    n = 0;
    while (busy && n < 80000) begin
      tick();
      n++;
      if (n == 500) begin
        clear = 1'b1;
        plot(50, 50, 3'b100, 1'b1);
      end
      if (n == 501) begin
        clear = 1'b0;
        bus.writeEn = 1'b0;
      end
    end
    chk("clr_busy_fall_writes", nwr - base, FBN + 2);
    drain("clr_drain", 20);
    tick(); tick();
    chk("clr_second_ignored", busy, 0);

    // Reset in the middle of a sweep.
    push_sweep(2000);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (!(bus.mem_we && bus.mem_addr == 17'd1000) && n < 3000) begin
      tick();
      n++;
    end
    chk("mid_reached_1000", bus.mem_addr, 1000);
    #2 reset_n = 1'b1;
    #1;
    chk("mid_rst_we", bus.mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", overflow, 0);
    exp_q.delete();
    #4 reset_n = 1'b0;
    tick();

    // Restarted sweep begins at address 0.
    push_sweep(10);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drain("restart_drain", 40);
    #1 reset_n = 1'b1;
    exp_q.delete();
    #4 reset_n = 1'b0;
    tick();
    chk("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
